// File: rtl/pool1_ctrl.sv
// Pool1 control sequencer.
// Streams each conv1 output map in raster order, drives the Pool1 FIFO/pool
// strobes and generates the conv2 input RAM write address/enable.
module pool1_ctrl #(
    parameter int IFM_SIZE              = 14,
    parameter int IFM_DEPTH             = 3,
    parameter int KERNAL_SIZE           = 2,
    parameter int RAM_READ_LATENCY      = 1,
    parameter int POOL_LATENCY          = 1,
    parameter int IFM_SIZE_NEXT         = (IFM_SIZE - KERNAL_SIZE) / 2 + 1,
    parameter int ADDRESS_SIZE_IFM      = $clog2(IFM_SIZE * IFM_SIZE),
    parameter int ADDRESS_SIZE_NEXT_IFM = $clog2(IFM_SIZE_NEXT * IFM_SIZE_NEXT),
    parameter int DEPTH_SEL_WIDTH       = (IFM_DEPTH > 1) ? $clog2(IFM_DEPTH) : 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    output logic                             ifm_rd_en,
    output logic [ADDRESS_SIZE_IFM-1:0]      ifm_rd_addr,
    output logic [DEPTH_SEL_WIDTH-1:0]       ifm_sel,
    output logic                             fifo_enable,
    output logic                             pool_enable,
    output logic                             ofm_wr_en,
    output logic [ADDRESS_SIZE_NEXT_IFM-1:0] ofm_wr_addr,
    output logic [DEPTH_SEL_WIDTH-1:0]       ofm_sel,
    output logic                             busy,
    output logic                             done
);

    localparam int RC_W         = (IFM_SIZE > 1) ? $clog2(IFM_SIZE) : 1;
    localparam int DRAIN_CYCLES = RAM_READ_LATENCY + 1 + POOL_LATENCY;
    localparam int DR_W         = $clog2(DRAIN_CYCLES);

    localparam logic [ADDRESS_SIZE_IFM-1:0]      LAST_RD    = ADDRESS_SIZE_IFM'(IFM_SIZE * IFM_SIZE - 1);
    localparam logic [ADDRESS_SIZE_NEXT_IFM-1:0] LAST_WR    = ADDRESS_SIZE_NEXT_IFM'(IFM_SIZE_NEXT * IFM_SIZE_NEXT - 1);
    localparam logic [DEPTH_SEL_WIDTH-1:0]       LAST_SEL   = DEPTH_SEL_WIDTH'(IFM_DEPTH - 1);
    localparam logic [DR_W-1:0]                  DRAIN_LAST = DR_W'(DRAIN_CYCLES - 1);
    localparam logic [RC_W-1:0]                  LAST_RC    = RC_W'(IFM_SIZE - 1);
    localparam logic [RC_W-1:0]                  K1         = RC_W'(KERNAL_SIZE - 1);
    localparam logic                             K1_PAR     = 1'((KERNAL_SIZE - 1) % 2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                             state_q, state_d;
    logic [ADDRESS_SIZE_IFM-1:0]        rd_addr_q, rd_addr_d;
    logic [DEPTH_SEL_WIDTH-1:0]         sel_q, sel_d;
    logic [DR_W-1:0]                    drain_q, drain_d;
    logic [RAM_READ_LATENCY-1:0]        rd_dly_q, rd_dly_d;
    logic [RC_W-1:0]                    row_q, row_d;
    logic [RC_W-1:0]                    col_q, col_d;
    logic                               pool_q, pool_d;
    logic [POOL_LATENCY-1:0]            wr_dly_q, wr_dly_d;
    logic [ADDRESS_SIZE_NEXT_IFM-1:0]   wr_addr_q, wr_addr_d;
    logic                               fifo_en;
    logic                               wr_en;
    logic                               bottom_right;

    assign fifo_en = rd_dly_q[RAM_READ_LATENCY-1];
    assign wr_en   = wr_dly_q[POOL_LATENCY-1];

    // (r-K+1) even is the same as r and K-1 having equal parity
    assign bottom_right = (row_q >= K1) && (col_q >= K1) &&
                          (row_q[0] == K1_PAR) && (col_q[0] == K1_PAR);

    // Sequencer next state: raster read, fixed-length drain, per-map select
    always_comb begin
        state_d   = state_q;
        rd_addr_d = rd_addr_q;
        sel_d     = sel_q;
        drain_d   = drain_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_READ;
                    rd_addr_d = '0;
                    sel_d     = '0;
                end
            end
            S_READ: begin
                if (rd_addr_q == LAST_RD) begin
                    state_d   = S_DRAIN;
                    rd_addr_d = '0;
                    drain_d   = '0;
                end else begin
                    rd_addr_d = rd_addr_q + ADDRESS_SIZE_IFM'(1);
                end
            end
            S_DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    drain_d = '0;
                    if (sel_q == LAST_SEL) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_READ;
                        sel_d   = sel_q + DEPTH_SEL_WIDTH'(1);
                    end
                end else begin
                    drain_d = drain_q + DR_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                sel_d   = '0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Strobe pipeline: read delay, window tracker, pool delay, write address
    always_comb begin
        rd_dly_d    = '0;
        rd_dly_d[0] = (state_q == S_READ);
        for (int unsigned i = 1; i < RAM_READ_LATENCY; i++) begin
            rd_dly_d[i] = rd_dly_q[i-1];
        end

        row_d = row_q;
        col_d = col_q;
        if (fifo_en) begin
            if (col_q == LAST_RC) begin
                col_d = '0;
                row_d = (row_q == LAST_RC) ? '0 : row_q + RC_W'(1);
            end else begin
                col_d = col_q + RC_W'(1);
            end
        end

        pool_d = fifo_en && bottom_right;

        wr_dly_d    = '0;
        wr_dly_d[0] = pool_q;
        for (int unsigned i = 1; i < POOL_LATENCY; i++) begin
            wr_dly_d[i] = wr_dly_q[i-1];
        end

        wr_addr_d = wr_addr_q;
        if (wr_en) begin
            wr_addr_d = (wr_addr_q == LAST_WR) ? '0 : wr_addr_q + ADDRESS_SIZE_NEXT_IFM'(1);
        end
    end

    // State and pipeline registers; synchronous active-low clear of everything
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            rd_addr_q <= '0;
            sel_q     <= '0;
            drain_q   <= '0;
            rd_dly_q  <= '0;
            row_q     <= '0;
            col_q     <= '0;
            pool_q    <= 1'b0;
            wr_dly_q  <= '0;
            wr_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            rd_addr_q <= rd_addr_d;
            sel_q     <= sel_d;
            drain_q   <= drain_d;
            rd_dly_q  <= rd_dly_d;
            row_q     <= row_d;
            col_q     <= col_d;
            pool_q    <= pool_d;
            wr_dly_q  <= wr_dly_d;
            wr_addr_q <= wr_addr_d;
        end
    end

    assign ifm_rd_en   = (state_q == S_READ);
    assign ifm_rd_addr = rd_addr_q;
    assign ifm_sel     = sel_q;
    assign ofm_sel     = sel_q;
    assign fifo_enable = fifo_en;
    assign pool_enable = pool_q;
    assign ofm_wr_en   = wr_en;
    assign ofm_wr_addr = wr_addr_q;
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);

endmodule

// File: tb/tb_pool1_ctrl.sv
// Bench for pool1_ctrl: three configurations share clock, reset and start;
// a timeline model derived from the layer timing rules predicts every output.
module tb_pool1_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    always #5 clk = ~clk;

    // d0: defaults, d1: IFM_SIZE=5/IFM_DEPTH=1, d2: both latencies 2
    logic       a_rd, a_fifo, a_pool, a_wr, a_busy, a_done;
    logic [7:0] a_rda;
    logic [5:0] a_wra;
    logic [1:0] a_isel, a_osel;
    logic       b_rd, b_fifo, b_pool, b_wr, b_busy, b_done;
    logic [4:0] b_rda;
    logic [1:0] b_wra;
    logic [0:0] b_isel, b_osel;
    logic       c_rd, c_fifo, c_pool, c_wr, c_busy, c_done;
    logic [7:0] c_rda;
    logic [5:0] c_wra;
    logic [1:0] c_isel, c_osel;

    pool1_ctrl dut0 (
        .clk(clk), .reset(reset), .start(start),
        .ifm_rd_en(a_rd), .ifm_rd_addr(a_rda), .ifm_sel(a_isel),
        .fifo_enable(a_fifo), .pool_enable(a_pool), .ofm_wr_en(a_wr),
        .ofm_wr_addr(a_wra), .ofm_sel(a_osel), .busy(a_busy), .done(a_done)
    );

    pool1_ctrl #(.IFM_SIZE(5), .IFM_DEPTH(1)) dut1 (
        .clk(clk), .reset(reset), .start(start),
        .ifm_rd_en(b_rd), .ifm_rd_addr(b_rda), .ifm_sel(b_isel),
        .fifo_enable(b_fifo), .pool_enable(b_pool), .ofm_wr_en(b_wr),
        .ofm_wr_addr(b_wra), .ofm_sel(b_osel), .busy(b_busy), .done(b_done)
    );

    pool1_ctrl #(.RAM_READ_LATENCY(2), .POOL_LATENCY(2)) dut2 (
        .clk(clk), .reset(reset), .start(start),
        .ifm_rd_en(c_rd), .ifm_rd_addr(c_rda), .ifm_sel(c_isel),
        .fifo_enable(c_fifo), .pool_enable(c_pool), .ofm_wr_en(c_wr),
        .ofm_wr_addr(c_wra), .ofm_sel(c_osel), .busy(c_busy), .done(c_done)
    );

    typedef struct packed {
        logic rd;
        int   rd_addr;
        logic fifo;
        logic pool;
        logic wr;
        int   wr_addr;
        logic in_map;
        int   sel;
        logic busy;
        logic done;
    } exp_t;

    int cS[3]  = '{14, 5, 14};
    int cD[3]  = '{3, 1, 3};
    int cL[3]  = '{1, 1, 2};
    int cPL[3] = '{1, 1, 2};

    int n_chk = 0;
    int n_fail = 0;
    int edge_n = -1;
    int pass_e[3];
    bit pass_on[3];
    int cnt_rd[3], cnt_fifo[3], cnt_pool[3], cnt_wr[3], cnt_done[3], last_done[3];
    int wr_cyc0[$], wr_adr0[$], wr_cyc2[$], wr_adr1[$];

    // Window index whose bottom-right is raster pixel p, or -1
    function automatic int win_of(input int S, input int K, input int p);
        int r, c, n;
        r = p / S;
        c = p % S;
        n = (S - K) / 2 + 1;
        if (r < K - 1 || c < K - 1) return -1;
        if (((r - K + 1) % 2) != 0 || ((c - K + 1) % 2) != 0) return -1;
        return ((r - K + 1) / 2) * n + (c - K + 1) / 2;
    endfunction

    function automatic int period(input int id);
        return cS[id] * cS[id] + cL[id] + 1 + cPL[id];
    endfunction

    // Outputs in the k-th cycle after start was accepted (k<1: idle)
    function automatic exp_t model(input int id, input int k);
        exp_t e;
        int S, P, tot, m, o, p, w;
        e = '0;
        S = cS[id];
        P = period(id);
        tot = cD[id] * P;
        if (k < 1 || k > tot + 1) return e;
        e.busy = 1'b1;
        if (k == tot + 1) begin
            e.done = 1'b1;
            return e;
        end
        m = (k - 1) / P;
        o = (k - 1) % P;
        e.in_map = 1'b1;
        e.sel = m;
        if (o < S * S) begin
            e.rd = 1'b1;
            e.rd_addr = o;
        end
        p = o - cL[id];
        if (p >= 0 && p < S * S) e.fifo = 1'b1;
        p = o - cL[id] - 1;
        if (p >= 0 && p < S * S && win_of(S, 2, p) >= 0) e.pool = 1'b1;
        p = o - cL[id] - 1 - cPL[id];
        if (p >= 0 && p < S * S) begin
            w = win_of(S, 2, p);
            if (w >= 0) begin
                e.wr = 1'b1;
                e.wr_addr = w;
            end
        end
        return e;
    endfunction

    task automatic chk(input string nm, input int t, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0d, expected %0d", nm, t, act, exp);
        end
    endtask

    task automatic cmp(input int id, input int t, input logic rd, input int rda,
                       input int isel, input logic fifo, input logic pool,
                       input logic wr, input int wra, input int osel,
                       input logic bsy, input logic dn);
        exp_t e;
        string p;
        e = model(id, pass_on[id] ? t - pass_e[id] : 0);
        p = $sformatf("d%0d", id);
        chk({p, ".ifm_rd_en"}, t, int'(rd), int'(e.rd));
        chk({p, ".fifo_enable"}, t, int'(fifo), int'(e.fifo));
        chk({p, ".pool_enable"}, t, int'(pool), int'(e.pool));
        chk({p, ".ofm_wr_en"}, t, int'(wr), int'(e.wr));
        chk({p, ".busy"}, t, int'(bsy), int'(e.busy));
        chk({p, ".done"}, t, int'(dn), int'(e.done));
        if (e.rd) chk({p, ".ifm_rd_addr"}, t, rda, e.rd_addr);
        if (e.wr) chk({p, ".ofm_wr_addr"}, t, wra, e.wr_addr);
        if (e.in_map) begin
            chk({p, ".ifm_sel"}, t, isel, e.sel);
            chk({p, ".ofm_sel"}, t, osel, e.sel);
        end
        if (rd) cnt_rd[id]++;
        if (fifo) cnt_fifo[id]++;
        if (pool) cnt_pool[id]++;
        if (wr) begin
            cnt_wr[id]++;
            if (id == 0) begin
                wr_cyc0.push_back(t);
                wr_adr0.push_back(wra);
            end
            if (id == 1) wr_adr1.push_back(wra);
            if (id == 2) wr_cyc2.push_back(t);
        end
        if (dn) begin
            cnt_done[id]++;
            last_done[id] = t;
        end
    endtask

    // Track when each DUT accepts start: only in an idle cycle, cleared by reset
    always @(posedge clk) begin
        edge_n++;
        for (int i = 0; i < 3; i++) begin
            if (!reset) begin
                pass_on[i] = 1'b0;
            end else if (start && (!pass_on[i] || edge_n - pass_e[i] > cD[i] * period(i) + 1)) begin
                pass_on[i] = 1'b1;
                pass_e[i] = edge_n;
            end
        end
    end

    // Compare all three DUTs against the model, away from the active edge
    always @(negedge clk) begin
        if (edge_n >= 0) begin
            cmp(0, edge_n + 1, a_rd, int'(a_rda), int'(a_isel), a_fifo, a_pool, a_wr,
                int'(a_wra), int'(a_osel), a_busy, a_done);
            cmp(1, edge_n + 1, b_rd, int'(b_rda), int'(b_isel), b_fifo, b_pool, b_wr,
                int'(b_wra), int'(b_osel), b_busy, b_done);
            cmp(2, edge_n + 1, c_rd, int'(c_rda), int'(c_isel), c_fifo, c_pool, c_wr,
                int'(c_wra), int'(c_osel), c_busy, c_done);
        end
    end

    task automatic wait_to(input int e);
        while (edge_n < e) @(negedge clk);
    endtask

    task automatic pulse_start(output int s);
        @(negedge clk);
        start = 1'b1;
        s = edge_n + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // One default pass from idle with hand-computed literal expectations
    task automatic one_pass_checks();
        int s, r0, f0, p0, w0, d0, r1, p1, w1, w2, q0, q1, q2;
        r0 = cnt_rd[0]; f0 = cnt_fifo[0]; p0 = cnt_pool[0]; w0 = cnt_wr[0]; d0 = cnt_done[0];
        r1 = cnt_rd[1]; p1 = cnt_pool[1]; w1 = cnt_wr[1]; w2 = cnt_wr[2];
        q0 = wr_cyc0.size(); q1 = wr_adr1.size(); q2 = wr_cyc2.size();
        pulse_start(s);
        wait_to(s + 620);
        chk("d0.rd_count", s, cnt_rd[0] - r0, 588);
        chk("d0.fifo_count", s, cnt_fifo[0] - f0, 588);
        chk("d0.pool_count", s, cnt_pool[0] - p0, 147);
        chk("d0.wr_count", s, cnt_wr[0] - w0, 147);
        chk("d0.done_count", s, cnt_done[0] - d0, 1);
        chk("d0.done_cycle", s, last_done[0] - s, 598);
        if (wr_cyc0.size() >= q0 + 8) begin
            chk("d0.wr0_cycle", s, wr_cyc0[q0] - s, 19);
            chk("d0.wr0_addr", s, wr_adr0[q0], 0);
            chk("d0.wr1_cycle", s, wr_cyc0[q0 + 1] - s, 21);
            chk("d0.wr1_addr", s, wr_adr0[q0 + 1], 1);
            chk("d0.wr7_cycle", s, wr_cyc0[q0 + 7] - s, 47);
            chk("d0.wr7_addr", s, wr_adr0[q0 + 7], 7);
            chk("d0.wr48_cycle", s, wr_cyc0[q0 + 48] - s, 199);
        end else begin
            chk("d0.wr_queue_len", s, wr_cyc0.size() - q0, 147);
        end
        chk("d1.rd_count", s, cnt_rd[1] - r1, 25);
        chk("d1.pool_count", s, cnt_pool[1] - p1, 4);
        chk("d1.wr_count", s, cnt_wr[1] - w1, 4);
        chk("d1.done_cycle", s, last_done[1] - s, 29);
        if (wr_adr1.size() >= q1 + 4) begin
            for (int i = 0; i < 4; i++) chk("d1.wr_addr_seq", s, wr_adr1[q1 + i], i);
        end else begin
            chk("d1.wr_queue_len", s, wr_adr1.size() - q1, 4);
        end
        chk("d2.wr_count", s, cnt_wr[2] - w2, 147);
        chk("d2.done_cycle", s, last_done[2] - s, 604);
        if (wr_cyc2.size() > q2) chk("d2.wr0_cycle", s, wr_cyc2[q2] - s, 21);
        else chk("d2.wr_queue_len", s, wr_cyc2.size() - q2, 147);
    endtask

    initial begin
        int s1, s2, d0, w0;
        reset = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        one_pass_checks();

        // start held high: second pass accepted only in the idle cycle after done
        d0 = cnt_done[0];
        @(negedge clk);
        start = 1'b1;
        s1 = edge_n + 1;
        wait_to(s1 + 599);
        start = 1'b0;
        wait_to(s1 + 1260);
        chk("d0.held_done_count", s1, cnt_done[0] - d0, 2);
        chk("d0.held_second_done", s1, last_done[0] - s1, 1197);

        // reset in the middle of map 0, sampled at edge 101 of the pass
        pulse_start(s2);
        wait_to(s2 + 100);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        w0 = cnt_wr[0];
        repeat (30) @(negedge clk);
        chk("d0.no_wr_after_reset", s2, cnt_wr[0] - w0, 0);

        one_pass_checks();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
